// File: rtl/aib_axi_follower_mem_responder.sv
// AXI4 slave RAM endpoint fed by the AIB-AXI bridge follower m_axi port.
// Independent write and read engines share one byte-writable RAM array.

module aib_axi_follower_mem_responder #(
  parameter int IDWIDTH   = 4,
  parameter int ADDRWIDTH = 32,
  parameter int DWIDTH    = 128,
  parameter int MEM_AW    = 10
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr,
  // write address
  input  logic [IDWIDTH-1:0]   s_axi_awid,
  input  logic [ADDRWIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]           s_axi_awlen,
  input  logic [2:0]           s_axi_awsize,
  input  logic [1:0]           s_axi_awburst,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  // write data
  input  logic [IDWIDTH-1:0]   s_axi_wid,
  input  logic [DWIDTH-1:0]    s_axi_wdata,
  input  logic [DWIDTH/8-1:0]  s_axi_wstrb,
  input  logic                 s_axi_wlast,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  // write response
  output logic [IDWIDTH-1:0]   s_axi_bid,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  // read address
  input  logic [IDWIDTH-1:0]   s_axi_arid,
  input  logic [ADDRWIDTH-1:0] s_axi_araddr,
  input  logic [7:0]           s_axi_arlen,
  input  logic [2:0]           s_axi_arsize,
  input  logic [1:0]           s_axi_arburst,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  // read data
  output logic [IDWIDTH-1:0]   s_axi_rid,
  output logic [DWIDTH-1:0]    s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rlast,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready
);

  localparam int NB    = DWIDTH / 8;
  localparam int DEPTH = 1 << MEM_AW;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [8:0] CNT_MAX = 9'h1FF;

  // shared RAM, never reset
  logic [DWIDTH-1:0] r_mem [0:DEPTH-1];

  // ---------------- write side state ----------------
  logic [1:0]         r_wstate;
  logic               r_awready;
  logic               r_wready;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic [IDWIDTH-1:0] r_bid;
  logic [MEM_AW-1:0]  r_wword;
  logic [7:0]         r_awlen;
  logic               r_wfixed;
  logic               r_werr;
  logic [8:0]         r_wcnt;

  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_b_hs;
  logic               w_aw_err;
  logic               w_mem_we;
  logic               w_len_ok;

  // ---------------- read side state ----------------
  logic [0:0]         r_rstate;
  logic               r_arready;
  logic               r_rvalid;
  logic               r_rlast;
  logic [1:0]         r_rresp;
  logic [IDWIDTH-1:0] r_rid;
  logic [DWIDTH-1:0]  r_rdata;
  logic [MEM_AW-1:0]  r_rword;
  logic [7:0]         r_arlen;
  logic               r_rfixed;
  logic               r_rerr;
  logic [7:0]         r_rcnt;

  logic               w_ar_hs;
  logic               w_r_hs;
  logic               w_ar_err;
  logic [MEM_AW-1:0]  w_ar_word;
  logic [MEM_AW-1:0]  w_rnext;

  logic               w_unused;

  // fields that carry no meaning for a 16-byte-beat RAM
  assign w_unused = ^{s_axi_wid,
                      s_axi_awaddr[3:0],
                      s_axi_araddr[3:0]};

  // write-side handshakes and burst error classification
  assign w_aw_hs  = r_awready & s_axi_awvalid;
  assign w_w_hs   = r_wready & s_axi_wvalid;
  assign w_b_hs   = r_bvalid & s_axi_bready;

  assign w_aw_err = (s_axi_awsize != 3'd4)
                  | s_axi_awburst[1]
                  | (|s_axi_awaddr[ADDRWIDTH-1:MEM_AW+4]);

  // beats after awlen+1 are absorbed without touching the RAM
  assign w_len_ok = (r_wcnt <= {1'b0, r_awlen});
  assign w_mem_we = w_w_hs & ~r_werr & w_len_ok & ~rst_wr;

  // write engine: AW accept, data beats, single B response
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      r_wword   <= '0;
      r_awlen   <= '0;
      r_wfixed  <= 1'b0;
      r_werr    <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_bid     <= s_axi_awid;
            r_wword   <= s_axi_awaddr[MEM_AW+3:4];
            r_awlen   <= s_axi_awlen;
            r_wfixed  <= (s_axi_awburst == 2'b00);
            r_werr    <= w_aw_err;
            r_wcnt    <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            if (r_wcnt != CNT_MAX) begin
              r_wcnt <= r_wcnt + 9'd1;
            end
            if (!r_wfixed) begin
              r_wword <= r_wword + 1'b1;
            end
            if (s_axi_wlast) begin
              // pre-increment count is the index of this last beat
              if (r_werr || (r_wcnt != {1'b0, r_awlen})) begin
                r_bresp <= RESP_SLVERR;
              end else begin
                r_bresp <= RESP_OKAY;
              end
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
          r_wstate  <= W_IDLE;
        end
      endcase
    end
  end

  // byte-granular RAM write port
  always_ff @(posedge clk_wr) begin
    if (w_mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) begin
          r_mem[r_wword][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // read-side handshakes and burst error classification
  assign w_ar_hs   = r_arready & s_axi_arvalid;
  assign w_r_hs    = r_rvalid & s_axi_rready;
  assign w_ar_word = s_axi_araddr[MEM_AW+3:4];

  assign w_ar_err  = (s_axi_arsize != 3'd4)
                   | s_axi_arburst[1]
                   | (|s_axi_araddr[ADDRWIDTH-1:MEM_AW+4]);

  assign w_rnext   = r_rfixed ? r_rword : (r_rword + 1'b1);

  // read engine: RAM read is issued on accept and on each
  // non-final R handshake, so beats stream without bubbles
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rword   <= '0;
      r_arlen   <= '0;
      r_rfixed  <= 1'b0;
      r_rerr    <= 1'b0;
      r_rcnt    <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_rid     <= s_axi_arid;
            r_rword   <= w_ar_word;
            r_arlen   <= s_axi_arlen;
            r_rfixed  <= (s_axi_arburst == 2'b00);
            r_rerr    <= w_ar_err;
            r_rcnt    <= '0;
            r_rdata   <= w_ar_err ? '0 : r_mem[w_ar_word];
            r_rresp   <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
            r_rlast   <= (s_axi_arlen == 8'd0);
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rcnt  <= r_rcnt + 8'd1;
              r_rword <= w_rnext;
              r_rdata <= r_rerr ? '0 : r_mem[w_rnext];
              r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
            end
          end
        end
        default: begin
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_rstate  <= R_IDLE;
        end
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_bid;

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = r_rdata;

endmodule

// File: tb/tb_aib_axi_follower_mem_responder.sv
// Bench for the AXI4 RAM responder: directed vectors, corner sequences,
// and random bursts against a word-level memory model.

module tb_aib_axi_follower_mem_responder;

  logic         clk_wr = 1'b0;
  logic         rst_wr = 1'b1;

  logic [3:0]   s_axi_awid = '0;
  logic [31:0]  s_axi_awaddr = '0;
  logic [7:0]   s_axi_awlen = '0;
  logic [2:0]   s_axi_awsize = '0;
  logic [1:0]   s_axi_awburst = '0;
  logic         s_axi_awvalid = 1'b0;
  logic         s_axi_awready;
  logic [3:0]   s_axi_wid = '0;
  logic [127:0] s_axi_wdata = '0;
  logic [15:0]  s_axi_wstrb = '0;
  logic         s_axi_wlast = 1'b0;
  logic         s_axi_wvalid = 1'b0;
  logic         s_axi_wready;
  logic [3:0]   s_axi_bid;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready = 1'b0;
  logic [3:0]   s_axi_arid = '0;
  logic [31:0]  s_axi_araddr = '0;
  logic [7:0]   s_axi_arlen = '0;
  logic [2:0]   s_axi_arsize = '0;
  logic [1:0]   s_axi_arburst = '0;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [3:0]   s_axi_rid;
  logic [127:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_rvalid;
  logic         s_axi_rready = 1'b0;

  aib_axi_follower_mem_responder #(
    .IDWIDTH(4), .ADDRWIDTH(32), .DWIDTH(128), .MEM_AW(10)
  ) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nb;
    logic [1:0]  bresp;
  } wvec_t;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [127:0] m_mem [0:1023];
  logic [127:0] wd [0:255];
  logic [15:0]  ws [0:255];
  logic [127:0] last_rdata;
  wvec_t        tv [7];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------- reference model, stated as the address/error rules ----------
  function automatic bit m_err(input logic [31:0] a,
                               input logic [2:0] sz,
                               input logic [1:0] bu);
    return (sz != 3'd4) || (bu > 2'd1) || (a[31:14] != 0);
  endfunction

  function automatic int m_word(input logic [31:0] a,
                                input logic [1:0] bu, input int i);
    int base;
    base = int'(a[13:4]);
    if (bu == 2'b00) return base;
    return (base + i) % 1024;
  endfunction

  function automatic logic [1:0] m_bresp(input logic [31:0] a,
                                         input logic [7:0] len,
                                         input logic [2:0] sz,
                                         input logic [1:0] bu,
                                         input int nb);
    if (m_err(a, sz, bu) || (nb - 1 != int'(len))) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [127:0] m_rd(input logic [31:0] a,
                                        input logic [7:0] len,
                                        input logic [2:0] sz,
                                        input logic [1:0] bu,
                                        input int i);
    if (m_err(a, sz, bu) || i > int'(len)) return '0;
    return m_mem[m_word(a, bu, i)];
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu,
                         input int nb);
    int w;
    if (m_err(a, sz, bu)) return;
    for (int i = 0; i < nb && i <= int'(len); i++) begin
      w = m_word(a, bu, i);
      for (int b = 0; b < 16; b++)
        if (ws[i][b]) m_mem[w][b*8 +: 8] = wd[i][b*8 +: 8];
    end
  endtask

  // ---------- bus tasks: drive at negedge, handshake at posedge ----------
  task automatic do_aw(input logic [3:0] id, input logic [31:0] a,
                       input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bu);
    int n = 0;
    @(negedge clk_wr);
    s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len;
    s_axi_awsize = sz; s_axi_awburst = bu; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 100) begin
      @(negedge clk_wr); n++;
    end
    chk("aw_ready", 128'(s_axi_awready), 128'(1'b1));
    @(posedge clk_wr); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] a,
                       input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bu);
    int n = 0;
    @(negedge clk_wr);
    s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len;
    s_axi_arsize = sz; s_axi_arburst = bu; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 100) begin
      @(negedge clk_wr); n++;
    end
    chk("ar_ready", 128'(s_axi_arready), 128'(1'b1));
    @(posedge clk_wr); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic do_b(input logic [3:0] id, input logic [1:0] exp);
    int n = 0;
    @(negedge clk_wr);
    s_axi_bready = 1'b1;
    while (!s_axi_bvalid && n < 100) begin
      @(negedge clk_wr); n++;
    end
    chk("b_valid", 128'(s_axi_bvalid), 128'(1'b1));
    chk("b_id", 128'(s_axi_bid), 128'(id));
    chk("b_resp", 128'(s_axi_bresp), 128'(exp));
    @(posedge clk_wr); #1;
    s_axi_bready = 1'b0;
    @(negedge clk_wr);
    chk("b_done", 128'(s_axi_bvalid), 128'(1'b0));
    chk("aw_idle", 128'(s_axi_awready), 128'(1'b1));
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input int nb,
                          input logic [1:0] exp_b);
    int n;
    do_aw(id, a, len, sz, bu);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk_wr);
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[i];
      s_axi_wstrb = ws[i]; s_axi_wlast = (i == nb - 1);
      s_axi_wid = id;
      n = 0;
      while (!s_axi_wready && n < 100) begin
        @(negedge clk_wr); n++;
      end
      chk("w_ready", 128'(s_axi_wready), 128'(1'b1));
      @(posedge clk_wr); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    m_write(a, len, sz, bu, nb);
    do_b(id, exp_b);
  endtask

  // mode 0: rready high, 1: toggle 1/0, 2: random
  task automatic do_read(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input int mode);
    int   beat = 0;
    int   cyc = 0;
    logic rr;
    logic [1:0] er;
    er = m_err(a, sz, bu) ? 2'b10 : 2'b00;
    do_ar(id, a, len, sz, bu);
    @(negedge clk_wr);
    chk("r_latency", 128'(s_axi_rvalid), 128'(1'b1));
    while (beat <= int'(len) && cyc < 2000) begin
      if (mode == 0) rr = 1'b1;
      else if (mode == 1) rr = (cyc % 2 == 0);
      else rr = 1'($urandom_range(0, 1));
      s_axi_rready = rr;
      chk("r_valid", 128'(s_axi_rvalid), 128'(1'b1));
      chk("r_id", 128'(s_axi_rid), 128'(id));
      chk("r_data", s_axi_rdata, m_rd(a, len, sz, bu, beat));
      chk("r_resp", 128'(s_axi_rresp), 128'(er));
      chk("r_last", 128'(s_axi_rlast), 128'(beat == int'(len)));
      last_rdata = s_axi_rdata;
      if (rr && s_axi_rvalid) beat++;
      cyc++;
      @(negedge clk_wr);
    end
    s_axi_rready = 1'b0;
    chk("r_beats", 128'(beat), 128'(int'(len) + 1));
    chk("r_end_valid", 128'(s_axi_rvalid), 128'(1'b0));
    chk("ar_idle", 128'(s_axi_arready), 128'(1'b1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  bu;
    int          nb;

    tv[0] = '{32'h300,  8'd0, 3'd4, 2'b01, 1, 2'b00};
    tv[1] = '{32'h310,  8'd3, 3'd2, 2'b01, 4, 2'b10};
    tv[2] = '{32'h350,  8'd3, 3'd4, 2'b01, 2, 2'b10};
    tv[3] = '{32'h390,  8'd1, 3'd4, 2'b01, 4, 2'b10};
    tv[4] = '{32'h3C0,  8'd1, 3'd4, 2'b10, 2, 2'b10};
    tv[5] = '{32'h4000, 8'd0, 3'd4, 2'b01, 1, 2'b10};
    tv[6] = '{32'h3E0,  8'd2, 3'd4, 2'b00, 3, 2'b00};

    // reset: all outputs low, ready rises one cycle after release
    repeat (3) @(negedge clk_wr);
    chk("rst_awready", 128'(s_axi_awready), 128'(1'b0));
    chk("rst_arready", 128'(s_axi_arready), 128'(1'b0));
    chk("rst_wready", 128'(s_axi_wready), 128'(1'b0));
    chk("rst_bvalid", 128'(s_axi_bvalid), 128'(1'b0));
    chk("rst_rvalid", 128'(s_axi_rvalid), 128'(1'b0));
    chk("rst_rdata", s_axi_rdata, 128'(0));
    chk("rst_rlast", 128'(s_axi_rlast), 128'(1'b0));
    chk("rst_ids", 128'({s_axi_bid, s_axi_rid}), 128'(0));
    chk("rst_resp", 128'({s_axi_bresp, s_axi_rresp}), 128'(0));
    rst_wr = 1'b0;
    chk("rel_awready0", 128'(s_axi_awready), 128'(1'b0));
    @(negedge clk_wr);
    chk("rel_awready1", 128'(s_axi_awready), 128'(1'b1));
    chk("rel_arready1", 128'(s_axi_arready), 128'(1'b1));

    // preload words 0..127 so every later check has known contents
    for (int i = 0; i < 128; i++) begin
      wd[i] = {$urandom, $urandom, $urandom, $urandom};
      ws[i] = 16'hFFFF;
    end
    do_write(4'd0, 32'h0, 8'd127, 3'd4, 2'b01, 128, 2'b00);

    // single write at 0x40 -> word 4
    wd[0] = 128'h0123456789ABCDEF00000000DEADBEEF;
    ws[0] = 16'hFFFF;
    do_write(4'd3, 32'h40, 8'd0, 3'd4, 2'b01, 1, 2'b00);
    do_read(4'd3, 32'h40, 8'd0, 3'd4, 2'b01, 0);
    chk("single_word4", last_rdata,
        128'h0123456789ABCDEF00000000DEADBEEF);

    // INCR burst of data i, streamed then back-pressured readback
    for (int i = 0; i < 8; i++) begin
      wd[i] = 128'(i); ws[i] = 16'hFFFF;
    end
    do_write(4'd1, 32'h100, 8'd7, 3'd4, 2'b01, 8, 2'b00);
    do_read(4'd2, 32'h100, 8'd7, 3'd4, 2'b01, 0);
    chk("incr_last_beat", last_rdata, 128'(7));
    do_read(4'd6, 32'h100, 8'd7, 3'd4, 2'b01, 1);

    // byte strobes into one FIXED word
    wd[0] = '1; ws[0] = 16'hFFFF;
    do_write(4'd1, 32'h200, 8'd0, 3'd4, 2'b01, 1, 2'b00);
    wd[0] = {16{8'h11}}; ws[0] = 16'h0001;
    wd[1] = {16{8'h22}}; ws[1] = 16'h0002;
    do_write(4'd1, 32'h200, 8'd1, 3'd4, 2'b00, 2, 2'b00);
    do_read(4'd1, 32'h200, 8'd0, 3'd4, 2'b01, 0);
    chk("strobe_fixed", last_rdata, {{14{8'hFF}}, 8'h22, 8'h11});

    // directed write vectors with hand-derived bresp
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 8; i++) begin
        wd[i] = {$urandom, $urandom, $urandom, $urandom};
        ws[i] = 16'hFFFF;
      end
      do_write(4'(t), tv[t].addr, tv[t].len, tv[t].size,
               tv[t].burst, tv[t].nb, tv[t].bresp);
      do_read(4'(t), tv[t].addr & 32'h3FF0, 8'd7, 3'd4, 2'b01, 2);
    end

    // out-of-range and bad-size reads
    do_read(4'd5, 32'h4000, 8'd3, 3'd4, 2'b01, 0);
    do_read(4'd9, 32'h100, 8'd1, 3'd2, 2'b01, 1);

    // random bursts against the model
    for (int it = 0; it < 40; it++) begin
      a   = 32'($urandom_range(0, 120)) << 4;
      a   = a | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a = a | 32'h0010_0000;
      len = 8'($urandom_range(0, 7));
      sz  = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd4;
      bu  = ($urandom_range(0, 9) == 0) ? 2'b10
                                        : 2'($urandom_range(0, 1));
      nb  = int'(len) + 1;
      if ($urandom_range(0, 5) == 0) nb = $urandom_range(1, 9);
      for (int i = 0; i < nb; i++) begin
        wd[i] = {$urandom, $urandom, $urandom, $urandom};
        ws[i] = 16'($urandom_range(0, 65535));
      end
      do_write(4'($urandom_range(0, 15)), a, len, sz, bu, nb,
               m_bresp(a, len, sz, bu, nb));
      do_read(4'($urandom_range(0, 15)), a, len, sz, bu, 2);
    end

    // reset during beat 2 of an 8-beat read
    do_ar(4'd7, 32'h100, 8'd7, 3'd4, 2'b01);
    s_axi_rready = 1'b1;
    @(negedge clk_wr);
    @(negedge clk_wr);
    @(negedge clk_wr);
    chk("rst_mid_beat2", s_axi_rdata, m_mem[18]);
    rst_wr = 1'b1;
    @(negedge clk_wr);
    chk("rst_mid_rvalid", 128'(s_axi_rvalid), 128'(1'b0));
    chk("rst_mid_arready", 128'(s_axi_arready), 128'(1'b0));
    rst_wr = 1'b0;
    s_axi_rready = 1'b0;
    @(negedge clk_wr);
    chk("rst_rel_arready", 128'(s_axi_arready), 128'(1'b1));
    chk("rst_rel_rvalid", 128'(s_axi_rvalid), 128'(1'b0));
    do_read(4'd2, 32'h100, 8'd7, 3'd4, 2'b01, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
